ads41_idelay_cal: RTL and testbench
===================================

ADS41_IDELAY_CAL -- requirements
Module: ads41_idelay_cal

Interface
REQ-001 SHALL have parameter NBITS, default 12: ADC word width; lanes NL = NBITS/2, lane i carries dout bits 2i and 2i+1.
REQ-002 SHALL have parameter NTAPS, default 32: IDELAY taps per lane, tap width TW = 5.
REQ-003 SHALL have parameter SETTLE, default 16: wait cycles after each tap load.
REQ-004 SHALL have parameter NSAMP, default 256: compared samples per tap.
REQ-005 SHALL have parameter MIN_EYE, default 4: minimum passing-window length.
REQ-006 SHALL have parameter PATTERN, default 12'hA5C: expected ADC test-pattern word.
REQ-007 SHALL have port clk, input, 1: sole clock, same domain as dout; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-009 SHALL have port start, input, 1: one-cycle pulse that begins calibration.
REQ-010 SHALL have port dout, input, NBITS: deserialised ADC word.
REQ-011 SHALL have port idelay_val, output, TW: tap value for the lane being loaded.
REQ-012 SHALL have port idelay_ctrl, output, NL: one-hot, one-cycle load strobe per lane.
REQ-013 SHALL have port busy, output, 1: calibration in progress.
REQ-014 SHALL have port done, output, 1: sticky; set on completion, cleared by the next accepted start.
REQ-015 SHALL have port lane_fail, output, NL: bit i set when lane i's best window is shorter than MIN_EYE.
REQ-016 SHALL have port lane_taps, output, NL*TW: final tap per lane, lane i at bits [i*TW +: TW].

Function
REQ-017 SHALL run FSM states IDLE, LOAD, SETTLE, CHECK, EVAL, APPLY, NEXT_LANE, DONE.
REQ-018 In IDLE, start=1 SHALL clear done, lane_fail, lane_taps and the window registers, set lane=0 and tap=0, then enter LOAD.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 LOAD SHALL last 1 cycle: idelay_val=tap and idelay_ctrl=(1<<lane); then enter SETTLE.
REQ-021 idelay_ctrl SHALL be 0 in every state except LOAD and APPLY.
REQ-022 SHALL hold idelay_val at its last driven value when it is not being loaded.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, counted by a down-counter, and SHALL ignore dout.
REQ-024 CHECK SHALL last exactly NSAMP cycles.
REQ-025 In CHECK, a tap passes only if dout[2i+1:2i] == PATTERN[2i+1:2i] on every sampled cycle, i = lane; any single mismatch marks the tap failed.
REQ-026 Per-tap latency SHALL be 1 + SETTLE + NSAMP + 1 cycles: LOAD, SETTLE, CHECK, EVAL.
REQ-027 EVAL, 1 cycle, on pass SHALL increment the current run length; if the run was 0, it SHALL record run_start = tap.
REQ-028 EVAL, on fail, SHALL close the current run and set the run length to 0.
REQ-029 When a run closes, or when tap = NTAPS-1 passes, the run SHALL replace the best window only if it is strictly longer; on a tie, the earliest window is kept.
REQ-030 Windows SHALL NOT wrap from tap NTAPS-1 to tap 0.
REQ-031 After EVAL, if tap < NTAPS-1, tap SHALL increment and the FSM SHALL return to LOAD; otherwise it SHALL enter APPLY.
REQ-032 APPLY, 1 cycle, SHALL compute center = best_start + ((best_len-1)>>1), with the shift in integer arithmetic (floor).
REQ-033 APPLY SHALL set center = 0 when best_len = 0.
REQ-034 APPLY SHALL drive idelay_val=center and idelay_ctrl=(1<<lane), and write lane_taps[lane]=center.
REQ-035 APPLY SHALL set lane_fail[lane] = (best_len < MIN_EYE); the center is still applied on failure.
REQ-036 NEXT_LANE SHALL clear the run and best registers.
REQ-037 NEXT_LANE SHALL go to DONE when lane = NL-1; otherwise it SHALL increment lane, set tap=0 and go to LOAD.
REQ-038 DONE SHALL set done=1 and go to IDLE next cycle.
REQ-039 busy SHALL be 1 in every state except IDLE.
REQ-040 Run and best lengths SHALL be TW+1 bits wide so that length NTAPS is representable without overflow.

Reset
REQ-041 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, even mid-calibration, with no further strobes issued.
REQ-042 On that reset, idelay_val, idelay_ctrl, busy, done, lane_fail, lane_taps and all counters SHALL be 0.
REQ-043 A start coincident with rst_n=0 SHALL be ignored.

Verification
REQ-044 Bench: dout=PATTERN at all taps, NBITS=12 -> each lane sees 32 LOAD strobes plus 1 APPLY strobe; every lane_taps=15 (0+31>>1); lane_fail=0; done=1 after 6*(32*(1+16+256+1)+2)+1 cycles.
REQ-045 Bench: lane 2 passes only at taps 9..20, others pass all -> lane_taps[2]=14, lane_fail[2]=0.
REQ-046 Bench: lane 0 windows 3..6 and 12..15 (tie, length 4) -> first kept, lane_taps[0]=4; a window 25..31 (7) instead -> lane_taps[0]=28 (run closed at last tap).
REQ-047 Bench: lane 1 never passes -> lane_taps[1]=0, lane_fail[1]=1; lane 3 window length 3 -> lane_fail[3]=1, center still applied.
REQ-048 Bench: single corrupted sample at CHECK cycle 255 of tap 10 -> tap 10 fails and splits the window.
REQ-049 Bench: rst_n=0 during lane 4 SETTLE -> next cycle busy=0, idelay_ctrl=0, lane_taps=0; start pulsed while busy -> no restart, strobe sequence unchanged.

Source files
------------

// File: rtl/ads41_idelay_cal.sv
// ads41_idelay_cal: sweeps each lane's IDELAY taps against a test pattern and centres the lane in its widest passing window
module ads41_idelay_cal #(
  parameter int NBITS = 12,
  parameter int NTAPS = 32,
  parameter int SETTLE = 16,
  parameter int NSAMP = 256,
  parameter int MIN_EYE = 4,
  parameter logic [NBITS-1:0] PATTERN = 12'hA5C,
  localparam int NL = NBITS / 2,
  localparam int TW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] dout,
  output logic [TW-1:0]    idelay_val,
  output logic [NL-1:0]    idelay_ctrl,
  output logic             busy,
  output logic             done,
  output logic [NL-1:0]    lane_fail,
  output logic [NL*TW-1:0] lane_taps
);
  localparam int CMAX = SETTLE > NSAMP ? SETTLE : NSAMP;
  localparam int CW = $clog2(CMAX + 1);
  localparam int LW = NL > 1 ? $clog2(NL) : 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(NL - 1);
  localparam logic [TW:0] MIN_LEN = (TW + 1)'(MIN_EYE);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_APPLY, S_NEXT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [TW-1:0] tap_q, tap_d;
  logic bad_q, bad_d;
  logic [TW:0] run_len_q, run_len_d, best_len_q, best_len_d, run_inc;
  logic [TW-1:0] run_start_q, run_start_d, best_start_q, best_start_d, run_start_nx, center;
  logic [TW-1:0] val_q, val_d;
  logic done_q, done_d;
  logic [NL-1:0] lane_fail_q, lane_fail_d;
  logic [NL*TW-1:0] lane_taps_q, lane_taps_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lane_d = lane_q;
    tap_d = tap_q;
    bad_d = bad_q;
    run_len_d = run_len_q;
    run_start_d = run_start_q;
    best_len_d = best_len_q;
    best_start_d = best_start_q;
    val_d = val_q;
    done_d = done_q;
    lane_fail_d = lane_fail_q;
    lane_taps_d = lane_taps_q;
    idelay_ctrl = '0;
    idelay_val = val_q;
    run_inc = run_len_q + 1'b1;
    run_start_nx = run_len_q == '0 ? tap_q : run_start_q;
    center = best_len_q == '0 ? '0 : best_start_q + TW'((best_len_q - 1'b1) >> 1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          lane_fail_d = '0;
          lane_taps_d = '0;
          run_len_d = '0;
          run_start_d = '0;
          best_len_d = '0;
          best_start_d = '0;
          lane_d = '0;
          tap_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        idelay_ctrl = NL'(1) << lane_q;
        idelay_val = tap_q;
        val_d = tap_q;
        bad_d = 1'b0;
        cnt_d = CW'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q == '0 ? CW'(NSAMP - 1) : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? S_CHECK : S_SETTLE;
      end
      S_CHECK: begin
        bad_d = bad_q | (dout[2*lane_q +: 2] != PATTERN[2*lane_q +: 2]);
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? S_EVAL : S_CHECK;
      end
      S_EVAL: begin
        if (!bad_q) begin
          run_len_d = run_inc;
          run_start_d = run_start_nx;
          if (tap_q == LAST_TAP && run_inc > best_len_q) begin
            best_len_d = run_inc;
            best_start_d = run_start_nx;
          end
        end else begin
          run_len_d = '0;
          if (run_len_q > best_len_q) begin
            best_len_d = run_len_q;
            best_start_d = run_start_q;
          end
        end
        tap_d = tap_q == LAST_TAP ? tap_q : tap_q + 1'b1;
        state_d = tap_q == LAST_TAP ? S_APPLY : S_LOAD;
      end
      S_APPLY: begin
        idelay_ctrl = NL'(1) << lane_q;
        idelay_val = center;
        val_d = center;
        lane_taps_d[lane_q*TW +: TW] = center;
        lane_fail_d[lane_q] = best_len_q < MIN_LEN;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        run_len_d = '0;
        run_start_d = '0;
        best_len_d = '0;
        best_start_d = '0;
        lane_d = lane_q == LAST_LANE ? lane_q : lane_q + 1'b1;
        tap_d = '0;
        state_d = lane_q == LAST_LANE ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      lane_q <= '0;
      tap_q <= '0;
      bad_q <= 1'b0;
      run_len_q <= '0;
      run_start_q <= '0;
      best_len_q <= '0;
      best_start_q <= '0;
      val_q <= '0;
      done_q <= 1'b0;
      lane_fail_q <= '0;
      lane_taps_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lane_q <= lane_d;
      tap_q <= tap_d;
      bad_q <= bad_d;
      run_len_q <= run_len_d;
      run_start_q <= run_start_d;
      best_len_q <= best_len_d;
      best_start_q <= best_start_d;
      val_q <= val_d;
      done_q <= done_d;
      lane_fail_q <= lane_fail_d;
      lane_taps_q <= lane_taps_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign lane_fail = lane_fail_q;
  assign lane_taps = lane_taps_q;
endmodule

// File: tb/tb_ads41_idelay_cal.sv
// tb_ads41_idelay_cal: emulates per-lane IDELAY eyes and checks every cycle against a cycle-offset model of the sweep
module tb_ads41_idelay_cal;
  localparam int NL = 6;
  localparam int NT = 32;
  localparam int TAPC = 1 + 16 + 256 + 1;
  localparam int LP = NT * TAPC + 2;
  localparam int RUN = NL * LP;
  localparam logic [11:0] PAT = 12'hA5C;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [11:0] dout = '0;
  logic [4:0] idelay_val;
  logic [5:0] idelay_ctrl;
  logic busy, done;
  logic [5:0] lane_fail;
  logic [29:0] lane_taps;
  ads41_idelay_cal dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dout(dout),
    .idelay_val(idelay_val), .idelay_ctrl(idelay_ctrl), .busy(busy),
    .done(done), .lane_fail(lane_fail), .lane_taps(lane_taps)
  );
  always #5 clk = ~clk;
  logic [31:0] pass_mask [NL];
  int corr_lane = -1;
  int corr_tap = -1;
  int cur_tap [NL] = '{default: 0};
  int strobes [NL] = '{default: 0};
  int k = 0;
  int exp_center [NL];
  logic exp_lfail [NL];
  logic run = 1'b0;
  int n = 0;
  logic m_done = 1'b0;
  logic [4:0] m_val = '0;
  logic [29:0] m_taps = '0;
  logic [5:0] m_fail = '0;
  int checks = 0;
  int errors = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (idelay_ctrl[i] === 1'b1) begin
        cur_tap[i] = int'(idelay_val);
        strobes[i] = strobes[i] + 1;
      end
    end
    k = (|idelay_ctrl) ? 0 : k + 1;
    for (int i = 0; i < NL; i++)
      dout[2*i +: 2] = (pass_mask[i][cur_tap[i]] && k >= 17 && k <= 272 &&
                        !(i == corr_lane && cur_tap[i] == corr_tap && k == 272)) ? PAT[2*i +: 2] : ~PAT[2*i +: 2];
  end
  function automatic void strobe_at(input int nn, output logic [5:0] c, output logic [4:0] v, output logic s);
    int ln, o;
    c = '0;
    v = '0;
    s = 1'b0;
    if (nn < RUN) begin
      ln = nn / LP;
      o = nn % LP;
      if (o < NT * TAPC && o % TAPC == 0) begin
        s = 1'b1;
        c = 6'(1) << ln;
        v = 5'(o / TAPC);
      end else if (o == NT * TAPC) begin
        s = 1'b1;
        c = 6'(1) << ln;
        v = 5'(exp_center[ln]);
      end
    end
  endfunction
  task automatic plan_run();
    logic [31:0] m;
    logic [63:0] w;
    int len, st;
    for (int i = 0; i < NL; i++) begin
      m = pass_mask[i];
      if (i == corr_lane) m[corr_tap] = 1'b0;
      len = 0;
      st = 0;
      for (int l = NT; l >= 1 && len == 0; l--) begin
        w = (64'(1) << l) - 64'(1);
        for (int s = 0; s + l <= NT && len == 0; s++)
          if (((64'(m) >> s) & w) == w) begin
            len = l;
            st = s;
          end
      end
      exp_center[i] = len == 0 ? 0 : st + (len - 1) / 2;
      exp_lfail[i] = len < 4;
    end
  endtask
  always @(posedge clk) begin
    logic [5:0] c;
    logic [4:0] v;
    logic s;
    if (!rst_n) begin
      run <= 1'b0;
      n <= 0;
      m_done <= 1'b0;
      m_val <= '0;
      m_taps <= '0;
      m_fail <= '0;
    end else if (run) begin
      strobe_at(n, c, v, s);
      if (s) m_val <= v;
      if (n < RUN && n % LP == NT * TAPC) begin
        m_taps[(n / LP) * 5 +: 5] <= 5'(exp_center[n / LP]);
        m_fail[n / LP] <= exp_lfail[n / LP];
      end
      if (n == RUN) begin
        run <= 1'b0;
        m_done <= 1'b1;
      end
      n <= n + 1;
    end else if (start) begin
      run <= 1'b1;
      n <= 0;
      m_done <= 1'b0;
      m_taps <= '0;
      m_fail <= '0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask
  task automatic tick();
    logic [5:0] c;
    logic [4:0] v;
    logic s;
    @(negedge clk);
    if (run) strobe_at(n, c, v, s);
    else begin
      c = '0;
      v = '0;
      s = 1'b0;
    end
    chk("busy", 64'(busy), 64'(run));
    chk("idelay_ctrl", 64'(idelay_ctrl), 64'(c));
    chk("idelay_val", 64'(idelay_val), 64'(s ? v : m_val));
    chk("done", 64'(done), 64'(m_done));
    chk("lane_taps", 64'(lane_taps), 64'(m_taps));
    chk("lane_fail", 64'(lane_fail), 64'(m_fail));
  endtask
  initial begin
    int cyc;
    int snap [NL];
    for (int i = 0; i < NL; i++) pass_mask[i] = '1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_outputs", 64'({idelay_ctrl, idelay_val, done, lane_fail, lane_taps}), 64'd0);
    pass_mask[0] = 32'h0000_F078;
    pass_mask[1] = 32'h0000_0000;
    pass_mask[2] = 32'h001F_FE00;
    pass_mask[3] = 32'h0070_0000;
    pass_mask[4] = 32'hFE00_0000;
    pass_mask[5] = 32'hFFFF_FFFF;
    plan_run();
    chk("model_c0_tie", 64'(exp_center[0]), 64'd4);
    chk("model_c1_none", 64'(exp_center[1]), 64'd0);
    chk("model_c2", 64'(exp_center[2]), 64'd14);
    chk("model_c3_short", 64'(exp_center[3]), 64'd21);
    chk("model_c4_edge", 64'(exp_center[4]), 64'd28);
    chk("model_c5_all", 64'(exp_center[5]), 64'd15);
    chk("model_fail", 64'({exp_lfail[5], exp_lfail[4], exp_lfail[3], exp_lfail[2], exp_lfail[1], exp_lfail[0]}), 64'b001010);
    for (int i = 0; i < NL; i++) snap[i] = strobes[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60000) begin
      tick();
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'd52621);
    chk("run1_lane_taps", 64'(lane_taps), 64'({5'd15, 5'd28, 5'd21, 5'd14, 5'd0, 5'd4}));
    chk("run1_lane_fail", 64'(lane_fail), 64'b001010);
    for (int i = 0; i < NL; i++) chk("strobes_per_lane", 64'(strobes[i] - snap[i]), 64'd33);
    repeat (3) tick();
    for (int i = 0; i < NL; i++) pass_mask[i] = '1;
    corr_lane = 0;
    corr_tap = 10;
    plan_run();
    chk("model_split", 64'(exp_center[0]), 64'd21);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clears_done", 64'(done), 64'd0);
    cyc = 0;
    while (n != 4 * LP + 5 && cyc < 40000) begin
      tick();
      cyc++;
      start = (n == 100);
    end
    start = 1'b0;
    chk("reach_lane4_settle", 64'(n), 64'(4 * LP + 5));
    chk("run2_lane_taps", 64'(lane_taps), 64'({5'd0, 5'd0, 5'd15, 5'd15, 5'd15, 5'd21}));
    chk("run2_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ctrl", 64'(idelay_ctrl), 64'd0);
    chk("midrst_taps", 64'(lane_taps), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NL; i++) snap[i] = strobes[i];
    repeat (5) tick();
    chk("post_rst_idle", 64'(busy), 64'd0);
    chk("post_rst_no_strobe", 64'(strobes[4] - snap[4]), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
